// File: rtl/cacheline_mem_scheduler_if.sv
// Cacheline port bundle: I-cache, D-cache and physical-memory sides.
// The scheduler takes the slave view; the surrounding system takes master.
interface cacheline_mem_scheduler_if #(
  parameter int s_offset = 4,
  parameter int size     = (2**s_offset)*8
);
  logic [31:0]     i_pmem_address;
  logic            i_pmem_read;
  logic [size-1:0] i_pmem_rdata;
  logic            i_pmem_resp;

  logic [31:0]     d_pmem_address;
  logic            d_pmem_read;
  logic            d_pmem_write;
  logic [size-1:0] d_pmem_wdata;
  logic [size-1:0] d_pmem_rdata;
  logic            d_pmem_resp;

  logic [size-1:0] pmem_rdata_c;
  logic            pmem_resp_c;
  logic [31:0]     pmem_address_c;
  logic            pmem_read_c;
  logic            pmem_write_c;
  logic [size-1:0] pmem_wdata_c;

  modport slave (
    input  i_pmem_address, i_pmem_read,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_address, d_pmem_read,
    input  d_pmem_write, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    input  pmem_rdata_c, pmem_resp_c,
    output pmem_address_c, pmem_read_c,
    output pmem_write_c, pmem_wdata_c
  );

  modport master (
    output i_pmem_address, i_pmem_read,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_address, d_pmem_read,
    output d_pmem_write, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    output pmem_rdata_c, pmem_resp_c,
    input  pmem_address_c, pmem_read_c,
    input  pmem_write_c, pmem_wdata_c
  );
endinterface

// File: rtl/cacheline_mem_scheduler.sv
// Shares one memory cacheline port between I-cache and D-cache.
// Commands are latched at grant; a counter bounds how long I can starve.
module cacheline_mem_scheduler #(
  parameter int s_offset   = 4,
  parameter int size       = (2**s_offset)*8,
  parameter int STARVE_MAX = 4
) (
  input logic                     clk,
  input logic                     rst,
  cacheline_mem_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } state_e;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [size-1:0] wd_q, wd_d;

  logic i_req;
  logic d_req;
  logic d_win;
  logic i_own;
  logic d_own;

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;
  assign d_win = d_req & (~i_req | (cnt_q < SMAX));
  assign i_own = (state_q == I_BUSY);
  assign d_own = (state_q == D_BUSY);

  // Grant arbitration, command latching and release on memory response
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: begin
        if (d_win) begin
          state_d = D_BUSY;
          addr_d  = bus.d_pmem_address;
          rd_d    = bus.d_pmem_read;
          wr_d    = bus.d_pmem_write & ~bus.d_pmem_read;
          wd_d    = bus.d_pmem_wdata;
          if (!i_req)
            cnt_d = '0;
          else if (cnt_q < SMAX)
            cnt_d = cnt_q + 4'd1;
        end else if (i_req) begin
          state_d = I_BUSY;
          addr_d  = bus.i_pmem_address;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      I_BUSY, D_BUSY: begin
        if (bus.pmem_resp_c) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // State and memory-side command registers; reset abandons any transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.pmem_address_c = addr_q;
  assign bus.pmem_read_c    = rd_q;
  assign bus.pmem_write_c   = wr_q;
  assign bus.pmem_wdata_c   = wd_q;

  // Responses reach only the owner, and only while it still asks
  assign bus.i_pmem_resp  = i_own & bus.pmem_resp_c & bus.i_pmem_read;
  assign bus.d_pmem_resp  = d_own & bus.pmem_resp_c & d_req;
  assign bus.i_pmem_rdata = i_own ? bus.pmem_rdata_c : '0;
  assign bus.d_pmem_rdata = d_own ? bus.pmem_rdata_c : '0;

endmodule

// File: doc/cacheline_mem_scheduler.md
Name: cacheline_mem_scheduler

Overview:
- Registered, stateful scheduler that shares the single physical-memory cacheline port between the I-cache (read-only) and the D-cache (read/write).
- Replaces pure combinational muxing with a granted-transaction FSM:
  - Address, command and write data are latched at grant and held stable until memory responds.
  - Anti-starvation counter guarantees I-cache progress under continuous D-cache traffic.
- Sits between the two caches and the cacheline adaptor / physical memory.

Parameters:
- s_offset, 4: log2 of cacheline bytes.
- size, (2**s_offset)*8: cacheline width in bits.
- STARVE_MAX, 4: consecutive D grants allowed while an I request waits; range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_pmem_address  input  32  I-cache line address.
- i_pmem_read  input  1  I-cache read request.
- i_pmem_rdata  output  size  line data to I-cache.
- i_pmem_resp  output  1  I-cache completion.
- d_pmem_address  input  32  D-cache line address.
- d_pmem_read  input  1  D-cache read request.
- d_pmem_write  input  1  D-cache write request.
- d_pmem_wdata  input  size  D-cache writeback line.
- d_pmem_rdata  output  size  line data to D-cache.
- d_pmem_resp  output  1  D-cache completion.
- pmem_rdata_c  input  size  memory-side read data.
- pmem_resp_c  input  1  memory-side completion.
- pmem_address_c  output  32  memory-side address, registered.
- pmem_read_c  output  1  memory-side read, registered.
- pmem_write_c  output  1  memory-side write, registered.
- pmem_wdata_c  output  size  memory-side write data, registered.

Behaviour:
- States: IDLE, I_BUSY, D_BUSY.
- Reset (async, rst=1):
  - State goes to IDLE; starvation counter goes to 0.
  - pmem_address_c=0, pmem_read_c=0, pmem_write_c=0, pmem_wdata_c=0.
  - All resp outputs 0; both rdata outputs 0.
  - Any in-flight memory transaction is abandoned.
- Arbitration in IDLE, evaluated each cycle:
  - D request (read|write) present and (no I request or counter<STARVE_MAX) -> go to D_BUSY.
  - Otherwise, I request present -> go to I_BUSY.
  - No request -> stay in IDLE.
- On entering D_BUSY:
  - Latch d_pmem_address into pmem_address_c.
  - Set pmem_read_c=d_pmem_read.
  - Set pmem_write_c=d_pmem_write&~d_pmem_read; read wins if both are asserted, which is an illegal input.
  - Latch pmem_wdata_c=d_pmem_wdata.
  - Counter increments if i_pmem_read was high at the grant edge (saturating at STARVE_MAX); otherwise it clears.
- On entering I_BUSY:
  - Latch i_pmem_address; set pmem_read_c=1, pmem_write_c=0.
  - Counter clears.
- Latency: a request sampled in IDLE at edge N drives the memory command from cycle N+1. Memory-side outputs are held constant for the whole BUSY state.
- In X_BUSY, when pmem_resp_c=1:
  - X_pmem_resp=1 combinationally in the same cycle, gated by the owner's request still being asserted.
  - X_pmem_rdata=pmem_rdata_c.
  - Next state is IDLE; pmem_read_c and pmem_write_c clear at that edge.
- Non-owner: resp stays 0 and rdata stays 0 at all times.
- Owner rdata outside the resp cycle is pmem_rdata_c passthrough while in its BUSY state, and 0 otherwise.
- Requester drops its request mid-transaction: the transaction still completes at memory, the response is not forwarded, and the FSM returns to IDLE.
- Request changes address or data mid-transaction: ignored, because the latched values are used.
- pmem_resp_c while in IDLE: ignored.
- Minimum gap between back-to-back transactions: one IDLE cycle.
- Requesters must drop their request in the cycle after resp.

Test Plan:
- Single I read:
  - Stimulus: i_pmem_read=1, addr 0x0000_0040; memory responds 3 cycles after command with data 0xA5..A5.
  - Required: pmem_read_c rises 1 cycle after request, pmem_address_c=0x40; i_pmem_resp pulses 1 cycle with rdata 0xA5..A5; d_pmem_resp stays 0.
- Simultaneous requests:
  - Stimulus: I read 0x100 and D write 0x200 (wdata 0x1234..) asserted in the same cycle.
  - Required: D granted first with pmem_write_c=1, addr 0x200, wdata matching; after D resp and one IDLE cycle, I read of 0x100 is issued.
- Starvation:
  - Stimulus: D requests back-to-back indefinitely; I read held high throughout.
  - Required: exactly 4 (STARVE_MAX) D transactions, then an I grant, then D resumes.
- Mid-transaction stability:
  - Stimulus: change d_pmem_address from 0x300 to 0x400 during D_BUSY.
  - Required: pmem_address_c stays 0x300 until resp.
- Abort and reset:
  - Stimulus: D drops its read before pmem_resp_c.
  - Required: no d_pmem_resp; return to IDLE after pmem_resp_c.
  - Stimulus: rst asserted asynchronously mid-I_BUSY.
  - Required: pmem_read_c=0 immediately, no resp, state IDLE, counter 0.
